// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator for the decode stage.
// Extracts and extends the RISC-V immediate (I/S/B/J/U, shamt, CSR zimm) from
// Instr and buffers {ExtImm, illegal} in a 2-entry in-order skid FIFO.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   flush           synchronous pipeline flush, empties the FIFO
//   in_valid/ready  input handshake (in_ready depends on registered state only)
//   ImmSrc          format select (ignored when AUTO_DECODE=1)
//   Instr           instruction word
//   out_valid/ready output handshake
//   ExtImm          extended immediate of the head entry (0 when empty)
//   illegal         head entry format was reserved/undecodable
module imm_gen_pipe #(
    parameter int unsigned XLEN        = 32,  // 32 or 64
    parameter int unsigned AUTO_DECODE = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      ImmSrc,
    input  logic [31:0]     Instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] ExtImm,
    output logic            illegal
);

    localparam logic [2:0] FMT_I  = 3'd0;
    localparam logic [2:0] FMT_S  = 3'd1;
    localparam logic [2:0] FMT_B  = 3'd2;
    localparam logic [2:0] FMT_J  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_SH = 3'd5;
    localparam logic [2:0] FMT_Z  = 3'd6;
    localparam logic [2:0] FMT_X  = 3'd7;

    // Opcode/funct3 to format; unknown opcodes map to the reserved format.
    function automatic logic [2:0] decode_fmt(input logic [6:0] op, input logic [2:0] f3);
        logic [2:0] f;
        case (op)
            7'b0000011, 7'b1100111: f = FMT_I;
            7'b0010011:             f = (f3 == 3'b001 || f3 == 3'b101) ? FMT_SH : FMT_I;
            7'b0100011:             f = FMT_S;
            7'b1100011:             f = FMT_B;
            7'b1101111:             f = FMT_J;
            7'b0110111, 7'b0010111: f = FMT_U;
            7'b1110011:             f = f3[2] ? FMT_Z : FMT_I;
            default:                f = FMT_X;
        endcase
        return f;
    endfunction

    logic [2:0]      fmt_c;
    logic [XLEN-1:0] imm_c;
    logic            ill_c;

    // Format source selection.
    always_comb begin
        fmt_c = ImmSrc;
        if (AUTO_DECODE != 0) begin
            fmt_c = decode_fmt(Instr[6:0], Instr[14:12]);
        end
    end

    // Immediate extraction: sign-extended formats start from a word of sign bits
    // and overwrite the low field.
    always_comb begin
        imm_c = '0;
        ill_c = 1'b0;
        case (fmt_c)
            FMT_I: begin
                imm_c        = {XLEN{Instr[31]}};
                imm_c[11:0]  = Instr[31:20];
            end
            FMT_S: begin
                imm_c        = {XLEN{Instr[31]}};
                imm_c[11:0]  = {Instr[31:25], Instr[11:7]};
            end
            FMT_B: begin
                imm_c        = {XLEN{Instr[31]}};
                imm_c[12:0]  = {Instr[31], Instr[7], Instr[30:25], Instr[11:8], 1'b0};
            end
            FMT_J: begin
                imm_c        = {XLEN{Instr[31]}};
                imm_c[20:0]  = {Instr[31], Instr[19:12], Instr[20], Instr[30:21], 1'b0};
            end
            FMT_U: begin
                imm_c        = {XLEN{Instr[31]}};
                imm_c[31:0]  = {Instr[31:12], 12'b0};
            end
            FMT_SH: begin
                if (XLEN == 64) imm_c[5:0] = Instr[25:20];
                else            imm_c[4:0] = Instr[24:20];
            end
            FMT_Z: begin
                imm_c[4:0]   = Instr[19:15];
            end
            default: begin
                ill_c        = 1'b1;
            end
        endcase
    end

    // FIFO state: head entry drives the outputs directly and is kept at zero
    // while empty, so ExtImm/illegal read 0 whenever out_valid is low.
    logic [1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] head_imm_q, head_imm_d, tail_imm_q, tail_imm_d;
    logic            head_ill_q, head_ill_d, tail_ill_q, tail_ill_d;
    logic            out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic            push_c, pop_c;

    assign push_c = in_valid && in_ready_q && !flush;
    assign pop_c  = out_valid_q && out_ready;

    // FIFO next state.
    always_comb begin
        cnt_d      = cnt_q;
        head_imm_d = head_imm_q;
        head_ill_d = head_ill_q;
        tail_imm_d = tail_imm_q;
        tail_ill_d = tail_ill_q;
        case (cnt_q)
            2'd0: begin
                if (push_c) begin
                    head_imm_d = imm_c;
                    head_ill_d = ill_c;
                    cnt_d      = 2'd1;
                end
            end
            2'd1: begin
                if (push_c && pop_c) begin
                    head_imm_d = imm_c;
                    head_ill_d = ill_c;
                end else if (push_c) begin
                    tail_imm_d = imm_c;
                    tail_ill_d = ill_c;
                    cnt_d      = 2'd2;
                end else if (pop_c) begin
                    head_imm_d = '0;
                    head_ill_d = 1'b0;
                    cnt_d      = 2'd0;
                end
            end
            default: begin
                // Full: in_ready is low, so only a pop can happen.
                if (pop_c) begin
                    head_imm_d = tail_imm_q;
                    head_ill_d = tail_ill_q;
                    tail_imm_d = '0;
                    tail_ill_d = 1'b0;
                    cnt_d      = 2'd1;
                end
            end
        endcase
        if (flush) begin
            cnt_d      = 2'd0;
            head_imm_d = '0;
            head_ill_d = 1'b0;
            tail_imm_d = '0;
            tail_ill_d = 1'b0;
        end
        out_valid_d = (cnt_d != 2'd0);
        in_ready_d  = (cnt_d != 2'd2);
    end

    // FIFO state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q       <= 2'd0;
            head_imm_q  <= '0;
            head_ill_q  <= 1'b0;
            tail_imm_q  <= '0;
            tail_ill_q  <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            head_imm_q  <= head_imm_d;
            head_ill_q  <= head_ill_d;
            tail_imm_q  <= tail_imm_d;
            tail_ill_q  <= tail_ill_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign ExtImm    = head_imm_q;
    assign illegal   = head_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: three instances (XLEN=32 explicit ImmSrc,
// XLEN=32 auto-decode, XLEN=64 auto-decode) share one stimulus stream and are
// checked against a queue-based reference of the FIFO and an arithmetic model
// of the immediate formats.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [2:0]  ImmSrc = 3'd0;
    logic [31:0] Instr = 32'd0;

    logic        m_ir, m_ov, m_ill, a_ir, a_ov, a_ill, w_ir, w_ov, w_ill;
    logic [31:0] m_imm, a_imm;
    logic [63:0] w_imm;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(0)) dut_m (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(m_ir),
        .ImmSrc(ImmSrc), .Instr(Instr), .out_valid(m_ov), .out_ready(out_ready),
        .ExtImm(m_imm), .illegal(m_ill));
    imm_gen_pipe #(.XLEN(32), .AUTO_DECODE(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_ir),
        .ImmSrc(ImmSrc), .Instr(Instr), .out_valid(a_ov), .out_ready(out_ready),
        .ExtImm(a_imm), .illegal(a_ill));
    imm_gen_pipe #(.XLEN(64), .AUTO_DECODE(1)) dut_w (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_ir),
        .ImmSrc(ImmSrc), .Instr(Instr), .out_valid(w_ov), .out_ready(out_ready),
        .ExtImm(w_imm), .illegal(w_ill));

    typedef struct packed {
        logic [31:0] m_imm;
        logic        m_ill;
        logic [31:0] a_imm;
        logic        a_ill;
        logic [63:0] w_imm;
        logic        w_ill;
    } exp_t;

    typedef logic [$bits(exp_t)+5:0] obs_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    // Interpret the low 'bits' bits of u as a two's-complement number.
    function automatic longint sx(input longint u, input int bits);
        return u[bits-1] ? u - (longint'(1) << bits) : u;
    endfunction

    function automatic logic [2:0] ref_fmt(input logic [31:0] ins);
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0000011, 7'b1100111: return 3'd0;
            7'b0010011:             return (f3 == 3'd1 || f3 == 3'd5) ? 3'd5 : 3'd0;
            7'b0100011:             return 3'd1;
            7'b1100011:             return 3'd2;
            7'b1101111:             return 3'd3;
            7'b0110111, 7'b0010111: return 3'd4;
            7'b1110011:             return f3[2] ? 3'd6 : 3'd0;
            default:                return 3'd7;
        endcase
    endfunction

    // Returns {illegal, 64-bit value}; XLEN=32 users take the low word.
    function automatic logic [64:0] ref_imm(input logic [2:0] fmt, input logic [31:0] ins, input bit x64);
        longint v;
        logic   ill;
        v   = 0;
        ill = 1'b0;
        case (fmt)
            3'd0: v = sx(longint'(ins[31:20]), 12);
            3'd1: v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
            3'd2: v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
                         + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
            3'd3: v = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                         + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
            3'd4: v = sx(longint'(ins[31:12]) * 4096, 32);
            3'd5: v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
            3'd6: v = longint'(ins[19:15]);
            default: begin v = 0; ill = 1'b1; end
        endcase
        return {ill, 64'(v)};
    endfunction

    function automatic exp_t make_exp(input logic [2:0] src, input logic [31:0] ins);
        exp_t e;
        logic [64:0] r;
        r = ref_imm(src, ins, 1'b0);          e.m_imm = r[31:0]; e.m_ill = r[64];
        r = ref_imm(ref_fmt(ins), ins, 1'b0); e.a_imm = r[31:0]; e.a_ill = r[64];
        r = ref_imm(ref_fmt(ins), ins, 1'b1); e.w_imm = r[63:0]; e.w_ill = r[64];
        return e;
    endfunction

    function automatic obs_t exp_obs();
        logic ov, ir;
        ov = (q.size() != 0);
        ir = (q.size() != 2);
        return {ov, ir, ov, ir, ov, ir, ov ? q[0] : exp_t'(0)};
    endfunction

    function automatic obs_t dut_obs();
        return {m_ov, m_ir, a_ov, a_ir, w_ov, w_ir, m_imm, m_ill, a_imm, a_ill, w_imm, w_ill};
    endfunction

    // One clock: advance the reference FIFO with the handshakes it predicts.
    task automatic step();
        bit   push, pop;
        exp_t e;
        push = in_valid && (q.size() != 2) && !flush && !reset;
        pop  = (q.size() != 0) && out_ready;
        e    = make_exp(ImmSrc, Instr);
        @(posedge clk);
        if (reset || flush) q.delete();
        else begin
            if (pop)  q.delete(0);
            if (push) q.push_back(e);
        end
        #1;
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        Instr    = 32'hFFF00093;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (dut_obs() !== exp_obs()) begin
                n_fail++;
                $display("FAIL reset state: got %h want %h", dut_obs(), exp_obs());
            end
        end
        n_checks++;
        if ({m_ov, m_ir, m_imm, m_ill} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset outputs: got ov=%b ir=%b imm=%h ill=%b want 0 1 0 0", m_ov, m_ir, m_imm, m_ill);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic test_formats();
        logic [2:0]  srcs[6];
        logic [31:0] ins[6];
        exp_t        want[6];
        srcs[0] = 3'd0; ins[0] = 32'hFFF00093;
        want[0] = '{32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        srcs[1] = 3'd2; ins[1] = 32'hFE000EE3;
        want[1] = '{32'hFFFFFFFC, 1'b0, 32'hFFFFFFFC, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        srcs[2] = 3'd7; ins[2] = 32'hFFF00093;
        want[2] = '{32'h0, 1'b1, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        srcs[3] = 3'd4; ins[3] = 32'h123452B7;
        want[3] = '{32'h12345000, 1'b0, 32'h12345000, 1'b0, 64'h0000000012345000, 1'b0};
        srcs[4] = 3'd5; ins[4] = 32'h43F0D093;
        want[4] = '{32'h1F, 1'b0, 32'h1F, 1'b0, 64'h3F, 1'b0};
        srcs[5] = 3'd7; ins[5] = 32'h0000007F;
        want[5] = '{32'h0, 1'b1, 32'h0, 1'b1, 64'h0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ImmSrc   = srcs[i];
            Instr    = ins[i];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            n_checks++;
            if (dut_obs() !== {6'b111111, want[i]}) begin
                n_fail++;
                $display("FAIL format vector %0d: got %h want %h", i, dut_obs(), {6'b111111, want[i]});
            end
            n_checks++;
            if (dut_obs() !== exp_obs()) begin
                n_fail++;
                $display("FAIL format model %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ImmSrc    = 3'd0;
        Instr     = 32'hFFF00093;
        step();
        ImmSrc    = 3'd6;
        Instr     = 32'h000FD073;
        step();
        ImmSrc    = 3'd1;
        Instr     = 32'hFE112E23;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({m_ov, m_ir, m_imm} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin
                n_fail++;
                $display("FAIL stall hold: got ov=%b ir=%b imm=%h want 1 0 ffffffff", m_ov, m_ir, m_imm);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) in_valid = 1'b0;
            n_checks++;
            if (dut_obs() !== exp_obs()) begin
                n_fail++;
                $display("FAIL drain order cycle %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            Instr  = $urandom;
            ImmSrc = 3'($urandom_range(0, 6));
            step();
        end
        flush = 1'b1;
        Instr = 32'h00500093;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({m_ov, m_ir, m_imm, m_ill} !== {1'b0, 1'b1, 32'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush empty: got ov=%b ir=%b imm=%h ill=%b want 0 1 0 0", m_ov, m_ir, m_imm, m_ill);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (dut_obs() !== exp_obs()) begin
                n_fail++;
                $display("FAIL flush drop: got %h want %h", dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        ImmSrc    = 3'd3;
        Instr     = 32'h0080006F;
        step();
        reset = 1'b1;
        Instr = 32'hFFF00093;
        step();
        reset    = 1'b0;
        in_valid = 1'b0;
        n_checks++;
        if ({m_ov, m_ir, m_imm, w_imm} !== {1'b0, 1'b1, 32'd0, 64'd0}) begin
            n_fail++;
            $display("FAIL midstream reset: got ov=%b ir=%b imm=%h wimm=%h want 0 1 0 0", m_ov, m_ir, m_imm, w_imm);
        end
        in_valid = 1'b1;
        ImmSrc   = 3'd0;
        Instr    = 32'h80000013;
        step();
        in_valid = 1'b0;
        n_checks++;
        if ({m_ov, m_imm} !== {1'b1, 32'hFFFFF800}) begin
            n_fail++;
            $display("FAIL post-reset latency: got ov=%b imm=%h want 1 fffff800", m_ov, m_imm);
        end
        n_checks++;
        if (dut_obs() !== exp_obs()) begin
            n_fail++;
            $display("FAIL post-reset model: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_random();
        logic [6:0] ops[10];
        ops = '{7'h03, 7'h67, 7'h13, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h33};
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 39) == 0);
            ImmSrc    = 3'($urandom_range(0, 7));
            Instr     = $urandom;
            if ($urandom_range(0, 4) != 0) Instr[6:0] = ops[$urandom_range(0, 9)];
            step();
            n_checks++;
            if (dut_obs() !== exp_obs()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        reset = 1'b0;
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_flush();
        test_reset_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
